// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of one shared SPI pin set: grants whole transactions,
// gates each chip-select with its grant and holds all selects high for a guard time.
module spi_bus_arbiter #(
  parameter int N_REQ        = 2,
  parameter int GUARD_CYCLES = 4
) (
  input  logic             SClk,
  input  logic             nReset,
  input  logic [N_REQ-1:0] Req,
  output logic [N_REQ-1:0] Grant,
  input  logic [N_REQ-1:0] ReqClkRunning,
  input  logic [N_REQ-1:0] ReqClkStretch,
  input  logic [N_REQ-1:0] ReqSPIDo,
  input  logic [N_REQ-1:0] ReqnSel,
  output logic             ClockRunning,
  output logic             ClockStretch,
  output logic             SPIDo,
  output logic [N_REQ-1:0] nSel,
  output logic             Busy,
  output logic [1:0]       Owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       owner_q;
  logic [1:0]       ptr_q;
  logic [3:0]       guard_cnt;
  logic [N_REQ-1:0] grant_q;

  // Requester vectors padded to the 4-entry maximum so a 2-bit owner index always fits.
  logic [3:0] req4;
  logic [3:0] run4;
  logic [3:0] stretch4;
  logic [3:0] do4;
  logic [2:0] pick;

  assign req4     = 4'(Req);
  assign run4     = 4'(ReqClkRunning);
  assign stretch4 = 4'(ReqClkStretch);
  assign do4      = 4'(ReqSPIDo);

  // Returns {found, index}: first set request scanning from ptr+1, wrapping.
  function automatic logic [2:0] pick_next(input logic [3:0] req, input logic [1:0] ptr);
    logic       found;
    logic [1:0] idx;
    logic [2:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, ptr} + 3'(i);
      if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
      if (!found && req[cand[1:0]]) begin
        found = 1'b1;
        idx   = cand[1:0];
      end
    end
    return {found, idx};
  endfunction

  assign pick = pick_next(req4, ptr_q);

  always_ff @(posedge SClk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd0;
      guard_cnt <= 4'd0;
      grant_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick[2]) begin
            state   <= OWN;
            owner_q <= pick[1:0];
            grant_q <= N_REQ'(4'b0001 << pick[1:0]);
          end
        end
        OWN: begin
          // Release only once the owner has also stopped its clock, so no byte is cut.
          if (!req4[owner_q] && !run4[owner_q]) begin
            state     <= GUARD;
            grant_q   <= '0;
            ptr_q     <= owner_q;
            guard_cnt <= 4'd0;
          end
        end
        GUARD: begin
          if (guard_cnt == 4'(GUARD_CYCLES - 1)) begin
            state     <= IDLE;
            guard_cnt <= 4'd0;
          end else begin
            guard_cnt <= guard_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Routing is purely combinational from registered state: no latency on SPI paths.
  always_comb begin
    ClockRunning = 1'b0;
    ClockStretch = 1'b0;
    SPIDo        = 1'b1;
    nSel         = '1;
    if (state == OWN) begin
      ClockRunning = run4[owner_q];
      ClockStretch = stretch4[owner_q];
      SPIDo        = do4[owner_q];
      for (int i = 0; i < N_REQ; i++) begin
        nSel[i] = (owner_q == 2'(i)) ? ReqnSel[i] : 1'b1;
      end
    end
  end

  assign Grant = grant_q;
  assign Busy  = (state != IDLE);
  assign Owner = owner_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: directed transactions, expected grants and
// received bytes queued at issue time, checked by independent negedge monitors.
module tb_spi_bus_arbiter;
  localparam int N = 2;
  localparam int G = 4;

  logic       SClk   = 1'b0;
  logic       nReset = 1'b0;
  logic [1:0] Req           = 2'b00;
  logic [1:0] ReqClkRunning = 2'b00;
  logic [1:0] ReqClkStretch = 2'b00;
  logic [1:0] ReqSPIDo      = 2'b11;
  logic [1:0] ReqnSel       = 2'b11;
  logic [1:0] Grant;
  logic       ClockRunning;
  logic       ClockStretch;
  logic       SPIDo;
  logic [1:0] nSel;
  logic       Busy;
  logic [1:0] Owner;

  spi_bus_arbiter #(.N_REQ(N), .GUARD_CYCLES(G)) dut (
    .SClk(SClk), .nReset(nReset), .Req(Req), .Grant(Grant),
    .ReqClkRunning(ReqClkRunning), .ReqClkStretch(ReqClkStretch),
    .ReqSPIDo(ReqSPIDo), .ReqnSel(ReqnSel),
    .ClockRunning(ClockRunning), .ClockStretch(ClockStretch), .SPIDo(SPIDo),
    .nSel(nSel), .Busy(Busy), .Owner(Owner)
  );

  always #5 SClk = ~SClk;

  int checks = 0;
  int errors = 0;

  logic [1:0] grant_exp_q[$];
  logic [8:0] byte_exp_q[$];
  int         gap_cnt  = 0;
  int         last_gap = 0;
  logic [1:0] prev_grant = 2'b00;
  logic [7:0] sh[2];
  int         bitcnt[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Device model: shifts SPIDo while its select is low and the clock runs.
  task automatic dev_step(input logic d);
    logic [8:0] e;
    if (!nSel[d] && ClockRunning) begin
      sh[d] = {sh[d][6:0], SPIDo};
      bitcnt[d]++;
      if (bitcnt[d] == 8) begin
        checks++;
        if (byte_exp_q.size() == 0) begin
          errors++;
          $display("FAIL dev_byte: dev%0d got %02h with nothing expected", d, sh[d]);
        end else begin
          e = byte_exp_q.pop_front();
          if (e !== {d, sh[d]}) begin
            errors++;
            $display("FAIL dev_byte: got dev%0d %02h expected dev%0d %02h", d, sh[d], e[8], e[7:0]);
          end
        end
        bitcnt[d] = 0;
      end
    end else if (nSel[d] && bitcnt[d] != 0) begin
      checks++;
      errors++;
      $display("FAIL dev_partial: dev%0d select rose after %0d bits", d, bitcnt[d]);
      bitcnt[d] = 0;
    end
  endtask

  always @(negedge SClk) begin
    logic       mk;
    logic [1:0] en;
    logic [6:0] act, exp;
    logic [1:0] ge;
    if (!nReset) begin
      bitcnt[0] = 0;
      bitcnt[1] = 0;
      gap_cnt    = 0;
      prev_grant = 2'b00;
    end else begin
      // Output routing model
      checks++;
      act = {Grant == 2'b11, nSel, ClockRunning, ClockStretch, SPIDo, 1'b0};
      if (Grant == 2'b00) begin
        exp = {1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
      end else begin
        mk = Grant[1];
        en = 2'b11;
        en[mk] = ReqnSel[mk];
        exp = {1'b0, en, ReqClkRunning[mk], ReqClkStretch[mk], ReqSPIDo[mk], 1'b0};
        act[0] = !(Busy && Owner == {1'b0, mk});
      end
      if (act !== exp) begin
        errors++;
        $display("FAIL routing: got %b expected %b (Grant=%b Owner=%0d Busy=%b)", act, exp, Grant, Owner, Busy);
      end
      // Grant order scoreboard
      if (Grant != prev_grant && Grant != 2'b00) begin
        checks++;
        if (grant_exp_q.size() == 0) begin
          errors++;
          $display("FAIL grant_order: got %b with nothing expected", Grant);
        end else begin
          ge = grant_exp_q.pop_front();
          if (Grant !== ge) begin
            errors++;
            $display("FAIL grant_order: got %b expected %b", Grant, ge);
          end
        end
        last_gap = gap_cnt;
        gap_cnt  = 0;
      end
      if (Grant == 2'b00) gap_cnt++;
      prev_grant = Grant;
      dev_step(1'b0);
      dev_step(1'b1);
    end
  end

  // Requester engine: request, wait for grant, shift a byte MSB first, release.
  task automatic send_byte(input logic k, input logic [7:0] b, input int drop_bit, output int lat);
    logic [7:0] s;
    s   = b;
    lat = 0;
    @(posedge SClk); #1;
    Req[k] = 1'b1;
    do begin
      @(posedge SClk); #1;
      lat++;
    end while (!Grant[k] && lat < 200);
    if (!Grant[k]) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: req%0d got no grant, required one within 200 cycles", k);
      Req[k] = 1'b0;
      return;
    end
    for (int n = 0; n < 8; n++) begin
      ReqnSel[k]       = 1'b0;
      ReqClkRunning[k] = 1'b1;
      ReqSPIDo[k]      = s[7];
      ReqClkStretch[k] = (n == 2);
      s = s << 1;
      if (n == drop_bit) Req[k] = 1'b0;
      @(posedge SClk); #1;
    end
    if (drop_bit < 8) chk("grant_hold_after_drop", {31'd0, Grant[k]}, 32'd1);
    ReqnSel[k]       = 1'b1;
    ReqClkRunning[k] = 1'b0;
    ReqClkStretch[k] = 1'b0;
    ReqSPIDo[k]      = 1'b1;
    Req[k]           = 1'b0;
    @(posedge SClk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0, lat1;
    // Reset values
    #12;
    chk("rst_grant", {30'd0, Grant}, 32'd0);
    chk("rst_nsel", {30'd0, nSel}, 32'd3);
    chk("rst_clkrun", {31'd0, ClockRunning}, 32'd0);
    chk("rst_stretch", {31'd0, ClockStretch}, 32'd0);
    chk("rst_spido", {31'd0, SPIDo}, 32'd1);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_owner", {30'd0, Owner}, 32'd0);
    @(posedge SClk); #1;
    nReset = 1'b1;
    repeat (2) @(posedge SClk);

    // Single request, 1-cycle grant latency, guard duration
    grant_exp_q.push_back(2'b01);
    byte_exp_q.push_back({1'b0, 8'h13});
    send_byte(1'b0, 8'h13, 8, lat0);
    chk("single_latency", lat0, 32'd1);
    chk("guard_busy", {31'd0, Busy}, 32'd1);
    repeat (G - 1) @(posedge SClk);
    #1 chk("guard_last_busy", {31'd0, Busy}, 32'd1);
    @(posedge SClk); #1;
    chk("guard_end_idle", {31'd0, Busy}, 32'd0);
    repeat (3) @(posedge SClk);

    // Simultaneous requests: requester 1 first, release-to-grant is G+1 cycles
    grant_exp_q.push_back(2'b10);
    grant_exp_q.push_back(2'b01);
    byte_exp_q.push_back({1'b1, 8'h3C});
    byte_exp_q.push_back({1'b0, 8'hC3});
    fork
      send_byte(1'b0, 8'hC3, 8, lat0);
      send_byte(1'b1, 8'h3C, 8, lat1);
    join
    chk("simul_first_latency", lat1, 32'd1);
    chk("guard_gap", last_gap, G + 1);
    repeat (8) @(posedge SClk);

    // Early drop of Req mid-byte
    grant_exp_q.push_back(2'b01);
    byte_exp_q.push_back({1'b0, 8'hA5});
    send_byte(1'b0, 8'hA5, 3, lat0);
    repeat (8) @(posedge SClk);

    // Isolation: non-owner drives select, data, clock and stretch noise
    grant_exp_q.push_back(2'b01);
    byte_exp_q.push_back({1'b0, 8'h22});
    fork
      send_byte(1'b0, 8'h22, 8, lat0);
      begin
        repeat (12) begin
          @(posedge SClk); #1;
          ReqnSel[1]       = 1'b0;
          ReqClkRunning[1] = 1'b1;
          ReqClkStretch[1] = ~ReqClkStretch[1];
          ReqSPIDo[1]      = ~ReqSPIDo[1];
        end
        @(posedge SClk); #1;
        ReqnSel[1]       = 1'b1;
        ReqClkRunning[1] = 1'b0;
        ReqClkStretch[1] = 1'b0;
        ReqSPIDo[1]      = 1'b1;
      end
    join
    repeat (8) @(posedge SClk);

    // Fairness: both requesters keep requesting through six transactions
    for (int t = 0; t < 3; t++) begin
      grant_exp_q.push_back(2'b10);
      grant_exp_q.push_back(2'b01);
      byte_exp_q.push_back({1'b1, 8'h61 + 8'(t)});
      byte_exp_q.push_back({1'b0, 8'h50 + 8'(t)});
    end
    fork
      for (int t = 0; t < 3; t++) send_byte(1'b0, 8'h50 + 8'(t), 8, lat0);
      for (int t = 0; t < 3; t++) send_byte(1'b1, 8'h61 + 8'(t), 8, lat1);
    join
    repeat (8) @(posedge SClk);

    // Reset mid-transfer: outputs return to idle values with no clock edge
    grant_exp_q.push_back(2'b10);
    @(posedge SClk); #1;
    Req[1] = 1'b1;
    lat1 = 0;
    do begin
      @(posedge SClk); #1;
      lat1++;
    end while (!Grant[1] && lat1 < 50);
    chk("pre_reset_grant", {30'd0, Grant}, 32'd2);
    for (int n = 0; n < 3; n++) begin
      ReqnSel[1]       = 1'b0;
      ReqClkRunning[1] = 1'b1;
      ReqSPIDo[1]      = n[0];
      @(posedge SClk); #1;
    end
    #1 nReset = 1'b0;
    #1;
    chk("midrst_nsel", {30'd0, nSel}, 32'd3);
    chk("midrst_grant", {30'd0, Grant}, 32'd0);
    chk("midrst_clkrun", {31'd0, ClockRunning}, 32'd0);
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_owner", {30'd0, Owner}, 32'd0);
    Req              = 2'b00;
    ReqnSel          = 2'b11;
    ReqClkRunning    = 2'b00;
    ReqSPIDo         = 2'b11;
    repeat (2) @(posedge SClk);
    #1 nReset = 1'b1;
    grant_exp_q.push_back(2'b01);
    byte_exp_q.push_back({1'b0, 8'h77});
    send_byte(1'b0, 8'h77, 8, lat0);
    chk("post_reset_latency", lat0, 32'd1);
    repeat (8) @(posedge SClk);

    chk("grant_queue_drained", grant_exp_q.size(), 32'd0);
    chk("byte_queue_drained", byte_exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one SPI master pin set (SPIMux inputs: clock-running, clock-stretch, data-out, chip-select) between N_REQ requester engines, e.g. RTC engine and flash/TF engine.
- Grants whole transactions round-robin and never cuts a byte in flight.
- Gates each device chip-select with its grant and enforces a chip-select-high guard time between owners.
- Sits between the requester engines and SPIMux.

Parameters:
- N_REQ, 2, number of requesters/devices (2..4).
- GUARD_CYCLES, 4, SClk cycles with all chip-selects high between one release and the next grant (1..15).

Ports:
- SClk  in  1  system clock; all state on rising edge.
- nReset  in  1  asynchronous active-low reset.
- Req  in  N_REQ  per-requester transaction request; held for the whole transaction.
- Grant  out  N_REQ  one-hot (or zero) ownership.
- ReqClkRunning  in  N_REQ  per-requester SPI clock-running.
- ReqClkStretch  in  N_REQ  per-requester clock-stretch.
- ReqSPIDo  in  N_REQ  per-requester next data-out bit.
- ReqnSel  in  N_REQ  per-requester active-low chip-select.
- ClockRunning  out  1  to SPIMux.
- ClockStretch  out  1  to SPIMux.
- SPIDo  out  1  to SPIMux.
- nSel  out  N_REQ  per-device chip-select to SPIMux.
- Busy  out  1  high in any state other than IDLE.
- Owner  out  2  index of the current or last owner.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; Grant=0; nSel all 1; ClockRunning=0; ClockStretch=0; SPIDo=1; Busy=0; Owner=0; priority pointer=0; guard counter=0.
- FSM states:
  - IDLE: if any Req, pick the first set Req scanning from (pointer+1) mod N_REQ, wrapping. On the next edge: Grant[k]=1, Owner=k, go to OWN. Latency from Req rising to Grant is 1 cycle.
  - OWN: route the owner's ReqClkRunning, ReqClkStretch and ReqSPIDo to the outputs. nSel[k]=ReqnSel[k]; all other nSel=1. When Req[k]=0 and ReqClkRunning[k]=0 in the same cycle, go to GUARD on the next edge and clear Grant. If Req[k] drops while ReqClkRunning[k]=1, hold OWN until clock-running falls, so the byte completes.
  - GUARD: Grant=0; all nSel=1; ClockRunning=0; ClockStretch=0; SPIDo=1. Set pointer=Owner. Count GUARD_CYCLES cycles, then go to IDLE. An arbitration decision can be made in that IDLE cycle, so release-to-next-Grant is GUARD_CYCLES+1 cycles.
- Outputs in IDLE match the GUARD values.
- Non-owner inputs are fully ignored; their chip-select is forced high even if asserted.
- Round-robin: the just-released owner has lowest priority. With a single requester it may be re-granted back-to-back, still after the guard time.
- Req changes on non-owners during OWN or GUARD only take effect at the next IDLE evaluation.
- Req pulses shorter than one cycle while in IDLE are still granted if sampled high. The requester then drops Req and releases after 1 OWN cycle, followed by the guard.
- All output muxing is combinational from registered state, so there is zero added latency on SPI data and clock-control paths.
- Reset mid-transaction returns to the reset values immediately (nSel high asynchronously). Requesters must restart their transactions.

Test Plan:
- Single request: Req=01 at t0 → Grant=01 at t0+1. The engine sends 8'h13 via ReqnSel[0]/ReqSPIDo; the device model receives 8'h13. nSel[1] stays 1 throughout.
- Simultaneous Req=11 after reset: requester 1 is granted first (pointer=0). After it releases: exactly 4 cycles with nSel=11 and Grant=00, then 1 IDLE cycle, then Grant=01.
- Early drop: requester 0 drops Req in the middle of byte 8'hA5 with ReqClkRunning=1 → Grant is held until clock-running falls, and the device receives the full 8'hA5 before nSel[0] rises.
- Fairness: both Req held high through 6 transactions → grants alternate 10,01,10,01,10,01 and neither requester is starved.
- Isolation: non-owner asserts ReqnSel=0, toggles ReqSPIDo and asserts ReqClkRunning during the owner's transfer 8'h22 → outputs follow the owner only; its nSel stays 1; the device receives 8'h22.
- Reset mid-transfer: nReset low during OWN → nSel=all 1, Grant=0, ClockRunning=0 with no clock edge needed. After release, the next Req is granted normally.
